// File: rtl/sample_packer_pkg.sv
// Shared definitions for the sample packer: width codes, word geometry,
// FSM states and the bits-per-clock legality rule.
package sample_packer_pkg;

    localparam logic [1:0] WIDTH_Q2 = 2'd0;
    localparam logic [1:0] WIDTH_4  = 2'd1;
    localparam logic [1:0] WIDTH_8  = 2'd2;

    localparam int WORD_W  = 16;
    localparam int MAX_BPC = 8;

    typedef enum logic {
        ST_IDLE,
        ST_PACK
    } state_t;

    // Bits per clock must be a non-zero power of two no larger than MAX_BPC,
    // so a sample never straddles two words and output stays <= 1 word / 2 clocks.
    function automatic logic bits_legal(input logic [7:0] bits);
        return (bits != 8'd0) && (bits <= 8'(MAX_BPC)) && ((bits & (bits - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/sample_packer_lane.sv
// lane_extract: per-channel slicer returning the channel's I/Q bits for the
// selected resolution, right-justified, together with the field length.
module lane_extract
    import sample_packer_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0]     comp_i,
    input  logic [SW-1:0]     comp_q,
    input  logic [3:0]        q2,
    input  logic [1:0]        width,
    input  logic [1:0]        shift,
    output logic [WORD_W-1:0] field,
    output logic [4:0]        len
);

    logic [SW-1:0] i_sh;
    logic [SW-1:0] q_sh;

    // Select the component bits for the requested width; width 3 yields an empty field.
    always_comb begin
        i_sh  = comp_i << shift;
        q_sh  = comp_q << shift;
        field = '0;
        len   = '0;
        case (width)
            WIDTH_Q2: begin
                field = {12'd0, q2};
                len   = 5'd4;
            end
            WIDTH_4: begin
                field = {8'd0, i_sh[SW-1 -: 4], q_sh[SW-1 -: 4]};
                len   = 5'd8;
            end
            WIDTH_8: begin
                field = WORD_W'({comp_i, comp_q});
                len   = 5'(2 * SW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sample_packer.sv
// sample_packer: keeps the enabled channels at the configured resolution and
// packs their bits MSB-first into 16-bit words for packet_streamer.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int SW  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH*2*SW-1:0] samp_iq,
    input  logic [NCH*4-1:0]    samp_q2,
    input  logic                enable,
    input  logic [NCH-1:0]      chan_en,
    input  logic [1:0]          width,
    input  logic [1:0]          shift,
    output logic [WORD_W-1:0]   data,
    output logic                data_en,
    output logic                cfg_err,
    output logic [WORD_W-1:0]   word_count
);

    localparam int BW = $clog2(NCH * 2 * SW + 1);

    state_t              state_q, state_d;
    logic [4:0]          fill_q, fill_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [NCH-1:0]      chan_q, chan_d;
    logic [1:0]          width_q, width_d;
    logic [1:0]          shift_q, shift_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [WORD_W-1:0]   word_count_q, word_count_d;
    logic                data_en_q, data_en_d;
    logic                cfg_err_q, cfg_err_d;

    logic                boundary;
    logic [NCH-1:0]      chan_eff;
    logic [1:0]          width_eff;
    logic [1:0]          shift_eff;
    logic [WORD_W-1:0]   lane_field [NCH];
    logic [4:0]          lane_len   [NCH];
    logic [WORD_W-1:0]   slice;
    logic [WORD_W-1:0]   word;
    logic [BW-1:0]       bits;
    logic                legal;
    logic [4:0]          fill_sum;

    // At a word boundary the live configuration is the one being latched, so
    // the first sample of a word already uses it; mid-word the latched copy rules.
    assign boundary  = (state_q == ST_IDLE);
    assign chan_eff  = boundary ? chan_en : chan_q;
    assign width_eff = boundary ? width   : width_q;
    assign shift_eff = boundary ? shift   : shift_q;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        lane_extract #(.SW(SW)) u_lane (
            .comp_i (samp_iq[(NCH-1-k)*2*SW + SW +: SW]),
            .comp_q (samp_iq[(NCH-1-k)*2*SW +: SW]),
            .q2     (samp_q2[(NCH-1-k)*4 +: 4]),
            .width  (width_eff),
            .shift  (shift_eff),
            .field  (lane_field[k]),
            .len    (lane_len[k])
        );
    end

    // Concatenate enabled lanes (ch1 first, ending in the LSBs) and form the candidate word.
    always_comb begin
        slice = '0;
        bits  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (chan_eff[k]) begin
                slice = (slice << lane_len[k]) | lane_field[k];
                bits  = bits + BW'(lane_len[k]);
            end
        end
        legal    = (width_eff inside {WIDTH_Q2, WIDTH_4, WIDTH_8}) && bits_legal(8'(bits));
        word     = ((boundary ? {WORD_W{1'b0}} : acc_q) << bits) | slice;
        fill_sum = fill_q + bits[4:0];
    end

    // Packing FSM: latch config at boundaries, accumulate, and emit full words.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        acc_d        = acc_q;
        chan_d       = chan_q;
        width_d      = width_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_en_d    = 1'b0;
        word_count_d = word_count_q;
        cfg_err_d    = cfg_err_q;

        if (boundary) begin
            chan_d    = chan_en;
            width_d   = width;
            shift_d   = shift;
            cfg_err_d = !legal;
        end

        if (enable && legal) begin
            if (fill_sum == 5'(WORD_W)) begin
                data_d       = word;
                data_en_d    = 1'b1;
                word_count_d = word_count_q + 16'd1;
                fill_d       = '0;
                state_d      = ST_IDLE;
            end else begin
                acc_d   = word;
                fill_d  = fill_sum;
                state_d = ST_PACK;
            end
        end else begin
            fill_d  = '0;
            state_d = ST_IDLE;
        end
    end

    // Control and output registers; reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fill_q       <= '0;
            chan_q       <= '0;
            width_q      <= WIDTH_Q2;
            shift_q      <= '0;
            data_q       <= '0;
            data_en_q    <= 1'b0;
            word_count_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            chan_q       <= chan_d;
            width_q      <= width_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_en_q    <= data_en_d;
            word_count_q <= word_count_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Accumulator contents are only meaningful while fill is non-zero.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign data       = data_q;
    assign data_en    = data_en_q;
    assign cfg_err    = cfg_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_sample_packer.sv
// Testbench for sample_packer: a bit-queue reference model predicts each
// cycle's outputs into a scoreboard that a separate monitor drains.
module tb_sample_packer;

    localparam int NCH = 4;
    localparam int SW  = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic [NCH*2*SW-1:0] samp_iq = '0;
    logic [NCH*4-1:0]    samp_q2 = '0;
    logic [NCH-1:0]      chan_en = '0;
    logic [1:0]          width = '0;
    logic [1:0]          shift = '0;
    logic [15:0]         data;
    logic                data_en;
    logic                cfg_err;
    logic [15:0]         word_count;

    sample_packer #(.NCH(NCH), .SW(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .samp_iq    (samp_iq),
        .samp_q2    (samp_q2),
        .enable     (enable),
        .chan_en    (chan_en),
        .width      (width),
        .shift      (shift),
        .data       (data),
        .data_en    (data_en),
        .cfg_err    (cfg_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          strobe;
        logic [15:0] data;
        logic [15:0] count;
        bit          err;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [SW-1:0] s_i  [NCH];
    logic [SW-1:0] s_q  [NCH];
    logic [1:0]    s_si [NCH];
    logic [1:0]    s_sq [NCH];

    bit             mbits[$];
    logic [NCH-1:0] m_chan;
    logic [1:0]     m_width;
    logic [1:0]     m_shift;
    bit             m_err;
    logic [15:0]    m_data;
    logic [15:0]    m_count;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mbits.delete();
        m_chan  = '0;
        m_width = '0;
        m_shift = '0;
        m_err   = 1'b0;
        m_data  = '0;
        m_count = '0;
    endtask

    // Reference: collect this sample's bits in order, append to the word queue.
    task automatic model_step(input bit en);
        bit   s[$];
        bit   legal;
        bit   strobe;
        logic [15:0] w;
        strobe = 1'b0;
        if (mbits.size() == 0) begin
            m_chan  = chan_en;
            m_width = width;
            m_shift = shift;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_chan[c]) begin
                for (int p = 0; p < 2; p++) begin
                    logic [SW-1:0] v;
                    logic [1:0]    v2;
                    v  = (p == 0) ? s_i[c]  : s_q[c];
                    v2 = (p == 0) ? s_si[c] : s_sq[c];
                    case (m_width)
                        2'd0: begin s.push_back(v2[1]); s.push_back(v2[0]); end
                        2'd1: for (int b = 0; b < 4; b++) s.push_back(v[SW-1-int'(m_shift)-b]);
                        2'd2: for (int b = SW-1; b >= 0; b--) s.push_back(v[b]);
                        default: ;
                    endcase
                end
            end
        end
        legal = (m_width != 2'd3) && (s.size() == 2 || s.size() == 4 || s.size() == 8);
        if (mbits.size() == 0) m_err = !legal;
        if (en && legal) begin
            foreach (s[k]) mbits.push_back(s[k]);
            if (mbits.size() == 16) begin
                for (int b = 0; b < 16; b++) w[15-b] = mbits[b];
                m_data  = w;
                m_count = m_count + 16'd1;
                strobe  = 1'b1;
                mbits.delete();
            end
        end else begin
            mbits.delete();
        end
        exp_q.push_back('{strobe, m_data, m_count, m_err});
    endtask

    task automatic cycle(input bit en, input logic [NCH-1:0] ce, input logic [1:0] w, input logic [1:0] sh);
        @(negedge clk);
        reset   = 1'b0;
        enable  = en;
        chan_en = ce;
        width   = w;
        shift   = sh;
        for (int c = 0; c < NCH; c++) begin
            samp_iq[(NCH-1-c)*2*SW + SW +: SW] = s_i[c];
            samp_iq[(NCH-1-c)*2*SW +: SW]      = s_q[c];
            samp_q2[(NCH-1-c)*4 +: 4]          = {s_si[c], s_sq[c]};
        end
        model_step(en);
    endtask

    task automatic rand_samples();
        for (int c = 0; c < NCH; c++) begin
            s_i[c]  = SW'($urandom);
            s_q[c]  = SW'($urandom);
            s_si[c] = 2'($urandom);
            s_sq[c] = 2'($urandom);
        end
    endtask

    // Monitor: one scoreboard entry per clock out of reset.
    always @(posedge clk) begin
        rec_t r;
        #1;
        if (reset === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got data_en %b expected an entry at %0t", data_en, $time);
            end else begin
                r = exp_q.pop_front();
                check("data_en", 16'(data_en), 16'(r.strobe));
                check("data", data, r.data);
                check("cfg_err", 16'(cfg_err), 16'(r.err));
                if (r.strobe) check("word_count", word_count, r.count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] ce;
        logic [1:0]     w;
        logic [1:0]     sh;
        int             a, b, runlen;

        model_reset();
        for (int c = 0; c < NCH; c++) begin
            s_i[c] = '0; s_q[c] = '0; s_si[c] = '0; s_sq[c] = '0;
        end
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data, 16'h0000);
        check("rst_data_en", 16'(data_en), 16'h0);
        check("rst_cfg_err", 16'(cfg_err), 16'h0);
        check("rst_word_count", word_count, 16'h0000);

        // 8-bit on one channel needs 16 bits per clock: illegal.
        s_i[0] = 8'h12; s_q[0] = 8'h34;
        repeat (8) cycle(1'b1, 4'b0001, 2'd2, 2'd0);
        @(posedge clk); #2;
        check("illegal_cfg_err", 16'(cfg_err), 16'h1);
        check("illegal_no_words", word_count, 16'h0000);

        // 4-bit truncated, one channel.
        for (int k = 0; k < 6; k++) begin
            s_i[0] = (k % 2) ? 8'hB0 : 8'hA0;
            s_q[0] = (k % 2) ? 8'hD0 : 8'hC0;
            cycle(1'b1, 4'b0001, 2'd1, 2'd0);
        end
        @(posedge clk); #2;
        check("w4_data", data, 16'hACBD);
        check("w4_count", word_count, 16'd3);
        check("w4_cfg_err_clear", 16'(cfg_err), 16'h0);

        // 2-bit quantized, two channels.
        cycle(1'b0, 4'b0011, 2'd0, 2'd0);
        s_si[0] = 2'b01; s_sq[0] = 2'b10; s_si[1] = 2'b11; s_sq[1] = 2'b00;
        repeat (6) cycle(1'b1, 4'b0011, 2'd0, 2'd0);
        @(posedge clk); #2;
        check("q2_data", data, 16'h6C6C);
        check("q2_count", word_count, 16'd6);

        // Channel change mid-word takes effect at the next word.
        cycle(1'b0, 4'b0001, 2'd1, 2'd1);
        rand_samples();
        cycle(1'b1, 4'b0001, 2'd1, 2'd1);
        for (int k = 0; k < 3; k++) begin
            rand_samples();
            cycle(1'b1, 4'b0010, 2'd1, 2'd1);
        end

        // Enable drop at fill=4 discards the partial word.
        cycle(1'b0, 4'b0001, 2'd0, 2'd0);
        rand_samples();
        cycle(1'b1, 4'b0001, 2'd0, 2'd0);
        repeat (3) cycle(1'b0, 4'b0001, 2'd0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            rand_samples();
            cycle(1'b1, 4'b0001, 2'd0, 2'd0);
        end

        // Asynchronous reset at fill=12.
        cycle(1'b0, 4'b0001, 2'd0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            rand_samples();
            cycle(1'b1, 4'b0001, 2'd0, 2'd0);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_data", data, 16'h0000);
        check("async_rst_data_en", 16'(data_en), 16'h0);
        check("async_rst_count", word_count, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rand_samples();
            cycle(1'b1, 4'b0001, 2'd0, 2'd0);
        end

        // Counter wrap.
        cycle(1'b0, 4'b0001, 2'd1, 2'd0);
        force dut.word_count_q = 16'hFFFF;
        #2 release dut.word_count_q;
        m_count = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            rand_samples();
            cycle(1'b1, 4'b0001, 2'd1, 2'd0);
        end
        @(posedge clk); #2;
        check("wrap_count", word_count, 16'h0000);
        check("wrap_strobe", 16'(data_en), 16'h1);

        // Randomized configurations, samples and enable.
        for (int n = 0; n < 60; n++) begin
            sh = 2'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                ce = NCH'($urandom);
                w  = 2'($urandom);
            end else begin
                a  = $urandom_range(0, NCH-1);
                b  = (a + $urandom_range(1, NCH-1)) % NCH;
                ce = '0;
                ce[a] = 1'b1;
                case ($urandom_range(0, 2))
                    0: w = 2'd0;
                    1: begin w = 2'd0; ce[b] = 1'b1; end
                    default: w = 2'd1;
                endcase
            end
            runlen = $urandom_range(1, 10);
            for (int r = 0; r < runlen; r++) begin
                rand_samples();
                cycle($urandom_range(0, 9) != 0, ce, w, sh);
            end
        end

        @(posedge clk); #3;
        check("drain", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
